// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: BCD mm:ss.cc stopwatch with start/stop, clear and lap.
// Live time and captured lap time feed the downstream per-digit display muxes;
// lap_valid is the suggested mux select.
// Optional build macro STOPWATCH_OVF_HALT_EN: saturate at 59:59.99 and pause
// (start_stop locked out until clear) instead of wrapping to 00:00.00.
module stopwatch_time_counter #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned DIGIT_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_stop,
    input  logic                   clear,
    input  logic                   lap,
    output logic [6*DIGIT_W-1:0]   time_bcd,
    output logic [6*DIGIT_W-1:0]   lap_bcd,
    output logic                   lap_valid,
    output logic                   running,
    output logic                   ovf
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned TW = 6 * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TW-1:0]     time_q, time_d;
    logic [TW-1:0]     lap_q, lap_d;
    logic              lap_valid_q, lap_valid_d;
    logic              running_q, running_d;
    logic              ovf_q, ovf_d;
    logic [TW-1:0]     inc_time;
    logic              carry;
    logic              tick;
`ifdef STOPWATCH_OVF_HALT_EN
    logic              sat_q, sat_d;
`endif

    // Digit wrap limits: s1 and m1 stop at 5, everything else at 9.
    function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned idx);
        return (idx == 3 || idx == 5) ? DIGIT_W'(5) : DIGIT_W'(9);
    endfunction

    // Ripple BCD increment of the live time; carry out marks rollover past 59:59.99.
    always_comb begin
        inc_time = time_q;
        carry    = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (carry) begin
                if (time_q[i*DIGIT_W +: DIGIT_W] == digit_max(i)) begin
                    inc_time[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    inc_time[i*DIGIT_W +: DIGIT_W] = time_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    // Next-state: clear dominates, then lap, then start_stop; prescaler runs only in RUN.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        time_d      = time_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        ovf_d       = 1'b0;
`ifdef STOPWATCH_OVF_HALT_EN
        sat_d       = sat_q;
`endif
        tick = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

        if (clear) begin
            state_d     = IDLE;
            presc_d     = '0;
            time_d      = '0;
            lap_d       = '0;
            lap_valid_d = 1'b0;
`ifdef STOPWATCH_OVF_HALT_EN
            sat_d       = 1'b0;
`endif
        end else begin
            if (state_q == RUN) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end

            if (tick) begin
                if (carry) begin
                    ovf_d = 1'b1;
`ifndef STOPWATCH_OVF_HALT_EN
                    time_d = inc_time;
`endif
                end else begin
                    time_d = inc_time;
                end
            end

            // Lap captures the pre-increment time, so it can share an edge with a tick.
            case (state_q)
                RUN: begin
                    lap_d       = time_q;
                    lap_valid_d = 1'b1;
                end
                PAUSE:   lap_valid_d = 1'b0;
                default: ;
            endcase
            if (!lap) begin
                lap_d       = lap_q;
                lap_valid_d = lap_valid_q;
            end

            if (start_stop) begin
                case (state_q)
                    IDLE:  state_d = RUN;
                    RUN:   state_d = PAUSE;
                    PAUSE: begin
`ifdef STOPWATCH_OVF_HALT_EN
                        if (!sat_q) state_d = RUN;
`else
                        state_d = RUN;
`endif
                    end
                    default: state_d = IDLE;
                endcase
            end

`ifdef STOPWATCH_OVF_HALT_EN
            if (tick && carry) begin
                state_d = PAUSE;
                sat_d   = 1'b1;
            end
`endif
        end

        running_d = (state_d == RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            time_q      <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef STOPWATCH_OVF_HALT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            time_q      <= time_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            ovf_q       <= ovf_d;
`ifdef STOPWATCH_OVF_HALT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign time_bcd  = time_q;
    assign lap_bcd   = lap_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign ovf       = ovf_q;

endmodule
